// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver: FSM states,
// sample points within a bit and the 3-sample majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int unsigned OS_RATE      = 16;
    localparam int unsigned SC_W         = 4;
    localparam int unsigned SAMP_LO      = 7;
    localparam int unsigned SAMP_MID     = 8;
    localparam int unsigned SAMP_HI      = 9;
    localparam int unsigned STOP_BIT_IDX = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Serial input and received-byte outputs of the UART receiver.
interface uart_rx_os16_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 mosi;
    logic [DATA_BITS-1:0] data;
    logic                 ok;
    logic                 frm_err;
    logic                 busy;

    modport master (output mosi, input data, ok, frm_err, busy);
    modport slave  (input mosi, output data, ok, frm_err, busy);
endinterface

// File: rtl/uart_tick16.sv
// Baud divider producing one tick every CLK_DIV cycles; restart re-phases it.
module uart_tick16 #(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver (8N1) with start validation, 3-sample
// majority voting and framing-error detection.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 27,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_os16_if.slave  rx
);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 2);
    localparam logic [SC_W-1:0] SC_LO   = SC_W'(SAMP_LO);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(SAMP_MID);
    localparam logic [SC_W-1:0] SC_HI   = SC_W'(SAMP_HI);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OS_RATE - 1);
    localparam logic [BC_W-1:0] BC_LAST_DATA = BC_W'(DATA_BITS);

    logic [1:0]           sync_q;
    logic                 rxs_prev_q;
    logic                 rxs_c;
    logic                 fall_c;
    logic                 tick_c;
    logic                 restart_c;
    logic                 vote_c;

    rx_state_e            state_q, state_d;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 s_lo_q, s_lo_d;
    logic                 s_mid_q, s_mid_d;
    logic                 ok_q, ok_d;
    logic                 frm_err_q, frm_err_d;
    logic                 busy_q, busy_d;

    // Two-flop synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rx.mosi};
            rxs_prev_q <= sync_q[1];
        end
    end

    assign rxs_c  = sync_q[1];
    assign fall_c = rxs_prev_q & ~rxs_c;
    assign vote_c = maj3(s_lo_q, s_mid_q, rxs_c);

    uart_tick16 #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_c),
        .tick    (tick_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sc_q      <= '0;
            bc_q      <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            s_lo_q    <= 1'b1;
            s_mid_q   <= 1'b1;
            ok_q      <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            bc_q      <= bc_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            s_lo_q    <= s_lo_d;
            s_mid_q   <= s_mid_d;
            ok_q      <= ok_d;
            frm_err_q <= frm_err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bc_d      = bc_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        s_lo_d    = s_lo_q;
        s_mid_d   = s_mid_q;
        ok_d      = 1'b0;
        frm_err_d = 1'b0;
        restart_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    state_d   = ST_START;
                    sc_d      = '0;
                    bc_d      = '0;
                    restart_c = 1'b1;
                end
            end

            ST_START, ST_DATA, ST_STOP: begin
                if (tick_c) begin
                    sc_d = sc_q + SC_W'(1);
                    if (sc_q == SC_LO) begin
                        s_lo_d = rxs_c;
                    end
                    if (sc_q == SC_MID) begin
                        s_mid_d = rxs_c;
                    end

                    if (state_q == ST_START) begin
                        if ((sc_q == SC_HI) && vote_c) begin
                            state_d = ST_IDLE;
                        end else if (sc_q == SC_LAST) begin
                            state_d = ST_DATA;
                            bc_d    = BC_W'(1);
                        end
                    end else if (state_q == ST_DATA) begin
                        if (sc_q == SC_HI) begin
                            shreg_d = {vote_c, shreg_q[DATA_BITS-1:1]};
                        end
                        if (sc_q == SC_LAST) begin
                            bc_d = bc_q + BC_W'(1);
                            if (bc_q == BC_LAST_DATA) begin
                                state_d = ST_STOP;
                            end
                        end
                    end else if (sc_q == SC_HI) begin
                        // Stop bit decided: leave without waiting for the bit to end
                        if (vote_c) begin
                            data_d  = shreg_q;
                            ok_d    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frm_err_d = 1'b1;
                            state_d   = ST_WAIT_HIGH;
                        end
                    end
                end
            end

            ST_WAIT_HIGH: begin
                if (rxs_c) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign rx.data    = data_q;
    assign rx.ok      = ok_q;
    assign rx.frm_err = frm_err_q;
    assign rx.busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: frames are driven bit by bit and the
// expected ok/frm_err events (value and cycle) are queued for a monitor.
module tb_uart_rx_os16;
    localparam int D        = 4;
    localparam int BIT_CYC  = 16 * D;
    localparam int EVT_TICK = 154;

    typedef struct {
        bit         is_ok;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic   clk;
    logic   rst_n;
    longint cyc;
    int     total;
    int     bad;
    exp_t   sbq[$];
    logic [7:0] last_good;

    uart_rx_os16_if #(.DATA_BITS(8)) bus ();

    uart_rx_os16 #(.CLK_DIV(D), .DATA_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (bus.ok || bus.frm_err)) begin
            chk("ok_frm_exclusive", {63'd0, bus.ok & bus.frm_err}, 64'd0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: ok=%0b frm_err=%0b data=%0h at cycle %0d",
                         bus.ok, bus.frm_err, bus.data, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("event_kind", {63'd0, bus.ok}, {63'd0, e.is_ok});
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("event_data", {56'd0, bus.data}, {56'd0, e.data});
                if (e.is_ok) chk("busy_at_ok", {63'd0, bus.busy}, 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        bus.mosi = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; stop_low>0 holds the stop bit low for that many bit
    // times, flip_rel inverts the line for one cycle, abort_rel resets mid-frame.
    task automatic send_frame(input logic [7:0] b, input int stop_low,
                              input int flip_rel, input int abort_rel);
        int     nbits;
        int     idx;
        logic   lvl;
        longint c0;
        exp_t   e;
        nbits = 10 + ((stop_low > 0) ? stop_low - 1 : 0);
        @(posedge clk);
        #1;
        c0 = cyc;
        if (abort_rel < 0) begin
            e.is_ok = (stop_low == 0);
            e.data  = (stop_low == 0) ? b : last_good;
            e.cyc   = c0 + 3 + longint'(EVT_TICK) * D;
            sbq.push_back(e);
            if (stop_low == 0) last_good = b;
        end
        for (int r = 0; r < nbits * BIT_CYC; r++) begin
            if (r > 0) begin
                @(posedge clk);
                #1;
            end
            if (r == abort_rel) begin
                chk("busy_mid_frame", {63'd0, bus.busy}, 64'd1);
                rst_n = 1'b0;
                #1;
                chk("rst_data", {56'd0, bus.data}, 64'd0);
                chk("rst_ok", {63'd0, bus.ok}, 64'd0);
                chk("rst_frm_err", {63'd0, bus.frm_err}, 64'd0);
                chk("rst_busy", {63'd0, bus.busy}, 64'd0);
                bus.mosi  = 1'b1;
                last_good = 8'h00;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            idx = r / BIT_CYC;
            if (idx == 0)      lvl = 1'b0;
            else if (idx <= 8) lvl = b[idx-1];
            else               lvl = (idx < 9 + stop_low) ? 1'b0 : 1'b1;
            if (r == flip_rel) lvl = ~lvl;
            bus.mosi = lvl;
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         flip;
        total     = 0;
        bad       = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        bus.mosi  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {56'd0, bus.data}, 64'd0);
        chk("reset_ok", {63'd0, bus.ok}, 64'd0);
        chk("reset_frm_err", {63'd0, bus.frm_err}, 64'd0);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        rst_n = 1'b1;
        idle(10);

        send_frame(8'hA5, 0, -1, -1);
        idle(20);
        chk("busy_after_a5", {63'd0, bus.busy}, 64'd0);

        // Short low glitch: start bit rejected by the vote
        @(posedge clk);
        #1;
        bus.mosi = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("busy_during_glitch", {63'd0, bus.busy}, 64'd1);
        repeat (10) begin @(posedge clk); #1; end
        bus.mosi = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        chk("busy_after_glitch", {63'd0, bus.busy}, 64'd0);
        idle(20);

        send_frame(8'h3C, 2, -1, -1);
        idle(40);
        chk("busy_after_break", {63'd0, bus.busy}, 64'd0);
        send_frame(8'h81, 0, -1, -1);

        send_frame(8'h00, 0, -1, -1);
        send_frame(8'hFF, 0, -1, -1);
        idle(30);

        send_frame(8'h55, 0, (16 * 4 + 8 + 1) * D, -1);
        idle(30);

        send_frame(8'hC3, 0, -1, 4 * BIT_CYC + BIT_CYC / 2);
        idle(30);
        send_frame(8'h7E, 0, -1, -1);
        idle(30);

        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            flip = -1;
            if ($urandom_range(0, 1) == 1)
                flip = (16 * int'($urandom_range(1, 8)) + int'($urandom_range(7, 9)) + 1) * D;
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 40)));
            send_frame(rb, 0, flip, -1);
        end

        idle(200);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        chk("final_busy", {63'd0, bus.busy}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
